// File: rtl/store_buffer.sv
// Store buffer: aligns SB/SH/SW stores into byte-lane words and drains
// them in order to data memory, splitting word-crossing stores in two.
module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [2:0]              st_addr_mode,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    output logic                    mem_write_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_byte_en,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    mem_ack,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t state, next;

    logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
    logic [7:0]              mask_q [DEPTH];
    logic [2*DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;

    logic [3:0]              size_mask;
    logic                    mode_ok;
    logic [1:0]              off;
    logic [DATA_WIDTH-1:0]   lane_keep;
    logic [7:0]              st_mask;
    logic [2*DATA_WIDTH-1:0] st_wide;
    logic [ADDR_WIDTH-1:0]   st_waddr;
    logic                    push, pop;

    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [7:0]              head_mask;
    logic [2*DATA_WIDTH-1:0] head_data;

    always_comb begin
        size_mask = 4'b0000;
        mode_ok   = 1'b0;
        unique case (st_addr_mode)
            MODE_B, MODE_BU: begin
                size_mask = 4'b0001;
                mode_ok   = 1'b1;
            end
            MODE_H, MODE_HU: begin
                size_mask = 4'b0011;
                mode_ok   = 1'b1;
            end
            MODE_W: begin
                size_mask = 4'b1111;
                mode_ok   = 1'b1;
            end
            default: ;
        endcase
    end

    // Bytes beyond the store size are cleared before shifting into lanes
    assign off       = st_addr[1:0];
    assign lane_keep = {{8{size_mask[3]}}, {8{size_mask[2]}},
                        {8{size_mask[1]}}, {8{size_mask[0]}}};
    assign st_mask   = {4'b0000, size_mask} << off;
    assign st_wide   = {{DATA_WIDTH{1'b0}}, st_data & lane_keep}
                       << {off, 3'b000};
    assign st_waddr  = {st_addr[ADDR_WIDTH-1:2], 2'b00};

    assign st_ready  = count < CW'(DEPTH);
    assign push      = st_valid && st_ready && mode_ok;
    assign empty     = (count == '0) && (state == IDLE);

    assign head_addr = addr_q[rd_ptr];
    assign head_mask = mask_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_waddr;
            mask_q[wr_ptr] <= st_mask;
            data_q[wr_ptr] <= st_wide;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        next           = state;
        pop            = 1'b0;
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_byte_en    = 4'b0000;
        mem_write_data = '0;
        unique case (state)
            IDLE: begin
                if (count != '0)
                    next = WR_LO;
            end
            WR_LO: begin
                mem_write_en   = 1'b1;
                mem_addr       = head_addr;
                mem_byte_en    = head_mask[3:0];
                mem_write_data = head_data[DATA_WIDTH-1:0];
                if (mem_ack) begin
                    if (head_mask[7:4] != 4'b0000) begin
                        next = WR_HI;
                    end else begin
                        pop  = 1'b1;
                        next = (count > CW'(1)) ? WR_LO : IDLE;
                    end
                end
            end
            WR_HI: begin
                mem_write_en   = 1'b1;
                mem_addr       = head_addr + ADDR_WIDTH'(4);
                mem_byte_en    = head_mask[7:4];
                mem_write_data = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
                if (mem_ack) begin
                    pop  = 1'b1;
                    next = (count > CW'(1)) ? WR_LO : IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && st_valid && st_ready && !mode_ok)
            $warning("store_buffer: bad addr_mode %b, store dropped",
                     st_addr_mode);
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomised bench for store_buffer against a byte-level write model,
// plus directed alignment, full, bad-mode and mid-drain reset cases.
module tb_store_buffer;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_addr_mode;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_write_data;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    store_buffer #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_addr_mode(st_addr_mode),
        .st_addr(st_addr),
        .st_data(st_data),
        .mem_write_en(mem_write_en),
        .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en),
        .mem_write_data(mem_write_data),
        .mem_ack(mem_ack),
        .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  left_q[$];

    // Scatter each store byte to (address+k); bytes past lane 3 fall
    // into the following word.
    task automatic model_push(input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] d);
        int nb;
        int pos;
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        logic [31:0] base;
        case (m)
            B, BU:   nb = 1;
            H, HU:   nb = 2;
            W:       nb = 4;
            default: nb = 0;
        endcase
        if (nb == 0) return;
        for (int j = 0; j < 2; j++) begin
            be[j] = 4'b0000;
            wd[j] = 32'h0;
        end
        for (int k = 0; k < nb; k++) begin
            pos = int'(a[1:0]) + k;
            be[pos/4][pos%4] = 1'b1;
            wd[pos/4][8*(pos%4) +: 8] = d[8*k +: 8];
        end
        base = a & ~32'h3;
        exp_q.push_back('{base, be[0], wd[0]});
        if (be[1] != 4'b0000)
            exp_q.push_back('{base + 32'd4, be[1], wd[1]});
        left_q.push_back((be[1] != 4'b0000) ? 2 : 1);
    endtask

    logic        hold = 1'b0;
    logic [68:0] hold_v;
    wr_t         w;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            left_q.delete();
            hold = 1'b0;
        end else begin
            chk("count", 64'(count), 64'(left_q.size()));
            chk("ready", 64'(st_ready), 64'(left_q.size() < 4));
            chk("empty", 64'(empty), 64'(left_q.size() == 0));
            if (!mem_write_en)
                chk("idle_out",
                    64'(|{mem_addr, mem_byte_en, mem_write_data}), 0);
            if (hold)
                chk("stable", 64'({mem_write_en, mem_addr, mem_byte_en,
                                   mem_write_data} == hold_v), 1);
            hold   = mem_write_en && !mem_ack;
            hold_v = {mem_write_en, mem_addr, mem_byte_en, mem_write_data};
            if (mem_write_en && mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(w.addr));
                    chk("wr_be", 64'(mem_byte_en), 64'(w.be));
                    chk("wr_data", 64'(mem_write_data), 64'(w.data));
                    left_q[0] = left_q[0] - 1;
                    if (left_q[0] == 0)
                        void'(left_q.pop_front());
                end
            end
            if (st_valid && st_ready)
                model_push(st_addr_mode, st_addr, st_data);
        end
    end

    task automatic send(input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        st_valid     = 1'b1;
        st_addr_mode = m;
        st_addr      = a;
        st_data      = d;
        @(negedge clk);
        while (!st_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_to", 64'(n < 50), 1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a,
                                input logic [3:0] be,
                                input logic [31:0] d, output int n);
        n = 0;
        @(negedge clk);
        while (!(mem_write_en && mem_ack) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_to"}, 64'(n < 20), 1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, "_be"}, 64'(mem_byte_en), 64'(be));
        chk({tag, "_data"}, 64'(mem_write_data), 64'(d));
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(negedge clk);
        while (!empty && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 64'(empty), 1);
    endtask

    int lat;
    logic [2:0] m_tab [5] = '{B, BU, H, HU, W};
    logic [31:0] ra;

    initial begin
        rst          = 1'b1;
        st_valid     = 1'b0;
        st_addr_mode = 3'b000;
        st_addr      = 32'h0;
        st_data      = 32'h0;
        mem_ack      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(st_ready), 1);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_count", 64'(count), 0);
        chk("rst_wen", 64'(mem_write_en), 0);
        chk("rst_out", 64'(|{mem_addr, mem_byte_en, mem_write_data}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(B, 32'h0000_0103, 32'hAABB_CCDD);
        @(negedge clk);
        chk("sb_count1", 64'(count), 1);
        chk("sb_idle", 64'(mem_write_en), 0);
        expect_write("sb", 32'h100, 4'b1000, 32'hDD00_0000, lat);
        chk("sb_lat", 64'(lat), 0);
        @(negedge clk);
        chk("sb_count0", 64'(count), 0);
        chk("sb_empty", 64'(empty), 1);

        send(H, 32'h0000_0203, 32'h0000_1234);
        expect_write("sh_lo", 32'h200, 4'b1000, 32'h3400_0000, lat);
        expect_write("sh_hi", 32'h204, 4'b0001, 32'h0000_0012, lat);
        chk("sh_hi_b2b", 64'(lat), 0);

        send(W, 32'hFFFF_FFFE, 32'h1122_3344);
        expect_write("sw_lo", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, lat);
        expect_write("sw_hi", 32'h0, 4'b0011, 32'h0000_1122, lat);
        drain();

        send(3'b111, 32'h0000_0300, 32'hDEAD_BEEF);
        repeat (3) begin
            @(negedge clk);
            chk("bad_count", 64'(count), 0);
            chk("bad_wen", 64'(mem_write_en), 0);
        end

        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            send(W, 32'h40 + 32'(4*i), 32'hC0DE_0000 + 32'(i));
        @(posedge clk);
        #1;
        st_valid     = 1'b1;
        st_addr_mode = W;
        st_addr      = 32'h50;
        st_data      = 32'hC0DE_0004;
        @(negedge clk);
        chk("full_ready", 64'(st_ready), 0);
        chk("full_count", 64'(count), 4);
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("pop_ready", 64'(st_ready), 1);
        chk("pop_count", 64'(count), 3);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("refill_count", 64'(count), 4);
        drain();

        mem_ack = 1'b0;
        send(W, 32'h0000_0602, 32'h5566_7788);
        send(W, 32'h0000_0700, 32'h1);
        send(W, 32'h0000_0704, 32'h2);
        @(negedge clk);
        chk("mid_wen", 64'(mem_write_en), 1);
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("mid_hi_addr", 64'(mem_addr), 32'h604);
        chk("mid_count", 64'(count), 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", 64'(mem_write_en), 0);
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_empty", 64'(empty), 1);
        chk("mid_rst_ready", 64'(st_ready), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_ack = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_wen", 64'(mem_write_en), 0);
        end

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            mem_ack  = $urandom_range(0, 3) != 0;
            st_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 31) == 0)
                st_addr_mode = 3'b011;
            else
                st_addr_mode = m_tab[$urandom_range(0, 4)];
            ra = $urandom;
            if ($urandom_range(0, 7) == 0)
                ra = 32'hFFFF_FFFC | (ra & 32'h3);
            st_addr = ra;
            st_data = $urandom;
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        drain();
        chk("model_left", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
